// File: rtl/dbus_arbiter_pkg.sv
// rtl/dbus_arbiter_pkg.sv - shared state encoding and master indices for the register bus arbiter
package dbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic other_master(input logic m);
        return ~m;
    endfunction

endpackage

// File: rtl/dbus_rr_arbiter.sv
// rtl/dbus_rr_arbiter.sv - combinational two-way round-robin pick
module dbus_rr_arbiter
    import dbus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_winner,
    output logic       o_valid
);

    // The pointer only matters on contention; a lone requester always wins.
    always_comb begin
        o_valid  = |i_req;
        o_winner = M0;
        if (i_req[M0] && i_req[M1]) begin
            o_winner = i_ptr;
        end else if (i_req[M1]) begin
            o_winner = M1;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master register data bus arbiter, setup/access/done bus cycle
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  M0_Req,
    input  logic                  M0_Wr,
    input  logic [ADDR_WIDTH-1:0] M0_Addr,
    input  logic [DATA_WIDTH-1:0] M0_Wdata,
    output logic [DATA_WIDTH-1:0] M0_Rdata,
    output logic                  M0_Ack,
    input  logic                  M1_Req,
    input  logic                  M1_Wr,
    input  logic [ADDR_WIDTH-1:0] M1_Addr,
    input  logic [DATA_WIDTH-1:0] M1_Wdata,
    output logic [DATA_WIDTH-1:0] M1_Rdata,
    output logic                  M1_Ack,
    output logic [ADDR_WIDTH-1:0] Addr,
    output logic [DATA_WIDTH-1:0] Dout,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic                  Wr,
    output logic                  Grant,
    output logic                  Busy
);

    state_t                r_state;
    logic                  r_ptr;
    logic                  r_txn_wr;
    logic                  r_grant;
    logic                  r_busy;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_winner;
    logic                  w_valid;
    logic                  w_win_wr;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0] w_win_wdata;

    dbus_rr_arbiter u_rr (
        .i_req    ({M1_Req, M0_Req}),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    assign w_win_wr    = (w_winner == M1) ? M1_Wr    : M0_Wr;
    assign w_win_addr  = (w_winner == M1) ? M1_Addr  : M0_Addr;
    assign w_win_wdata = (w_winner == M1) ? M1_Wdata : M0_Wdata;

    // Address and data are driven from the grant edge so they are stable
    // for a full cycle before the single Wr strobe in ACCESS.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= M0;
            r_txn_wr <= 1'b0;
            r_grant  <= M0;
            r_busy   <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_dout   <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_wr   <= 1'b0;
                    if (w_valid) begin
                        r_grant  <= w_winner;
                        r_busy   <= 1'b1;
                        r_txn_wr <= w_win_wr;
                        r_addr   <= w_win_addr;
                        r_dout   <= w_win_wr ? w_win_wdata : '0;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_wr    <= r_txn_wr;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    r_wr   <= 1'b0;
                    r_addr <= '0;
                    r_dout <= '0;
                    if (r_grant == M1) begin
                        r_ack1 <= 1'b1;
                        if (!r_txn_wr) begin
                            r_rdata1 <= Din;
                        end
                    end else begin
                        r_ack0 <= 1'b1;
                        if (!r_txn_wr) begin
                            r_rdata0 <= Din;
                        end
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ptr   <= other_master(r_grant);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Addr     = r_addr;
    assign Dout     = r_dout;
    assign Wr       = r_wr;
    assign Grant    = r_grant;
    assign Busy     = r_busy;
    assign M0_Ack   = r_ack0;
    assign M1_Ack   = r_ack1;
    assign M0_Rdata = r_rdata0;
    assign M1_Rdata = r_rdata1;

endmodule
